// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported memory between two bus masters.
// It runs one transaction at a time and returns a single-cycle acknowledge to the winner.
//
//  state  | meaning
//  IDLE   | no transaction; arbitrate pending requests
//  ACCESS | latched address on the memory; writes strobe once, reads wait out RD_LAT
//  DONE   | acknowledge pulse to the owner; memory bus back to idle
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dout,
    output logic          mem_w,
    input  logic [DW-1:0] mem_din,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    state_t        state;
    state_t        state_next;
    logic [2:0]    lat_cnt;
    logic          owner_q;
    logic          last_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          grant;
    logic          grant_port;
    logic          lat_done;
    logic          capture;

    // On a tie, round-robin hands the grant to whichever port was not served last.
    always_comb begin
        grant = req0 | req1;
        if (req0 && req1) begin
            grant_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            grant_port = req1;
        end
    end

    assign lat_done = (lat_cnt == 3'd0);
    assign capture  = (state == ACCESS) && !wr_q && lat_done;

    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_dout   = '0;
        mem_w      = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy     = 1'b1;
                mem_addr = addr_q;
                if (wr_q) begin
                    mem_w      = 1'b1;
                    mem_dout   = wdata_q;
                    state_next = DONE;
                end else if (lat_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                ack0       = ~owner_q;
                ack1       = owner_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant) begin
                owner_q <= grant_port;
                wr_q    <= grant_port ? wr1 : wr0;
                addr_q  <= grant_port ? addr1 : addr0;
                wdata_q <= grant_port ? wdata1 : wdata0;
                lat_cnt <= LAT_LOAD;
            end else if (state == ACCESS && !lat_done) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            // Only the owner's read-data register ever changes.
            if (capture) begin
                if (owner_q) begin
                    rdata1_q <= mem_din;
                end else begin
                    rdata0_q <= mem_din;
                end
            end
            if (state == DONE) begin
                last_q <= owner_q;
            end
        end
    end

    assign owner  = owner_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four parameter variants share one stimulus stream.
// A transaction-timeline model checks every output each cycle; directed literals pin the model.
module tb_mem_port_arbiter;

    localparam int N = 4;

    bit          clock;
    logic        reset;
    logic        req0, wr0, req1, wr1;
    logic [15:0] addr0, wdata0, addr1, wdata1;

    logic        ack0_s [N];
    logic        ack1_s [N];
    logic        mem_w_s [N];
    logic        busy_s [N];
    logic        owner_s [N];
    logic [15:0] rdata0_s [N];
    logic [15:0] rdata1_s [N];
    logic [15:0] mem_addr_s [N];
    logic [15:0] mem_dout_s [N];
    logic [15:0] mem_din_s [N];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int rdl_of(input int k);
        return (k == 1) ? 2 : (k == 2) ? 3 : 1;
    endfunction

    function automatic int fpr_of(input int k);
        return (k == 3) ? 1 : 0;
    endfunction

    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'h00:   return 16'hDEAD;
            8'h20:   return 16'h1234;
            8'h40:   return 16'h5A5A;
            default: return {8'h77, a};
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_port_arbiter #(
            .AW(16), .DW(16),
            .RD_LAT((g == 1) ? 2 : (g == 2) ? 3 : 1),
            .FIXED_PRIO((g == 3) ? 1 : 0)
        ) u_dut (
            .clock(clock), .reset(reset),
            .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
            .ack0(ack0_s[g]), .rdata0(rdata0_s[g]),
            .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
            .ack1(ack1_s[g]), .rdata1(rdata1_s[g]),
            .mem_addr(mem_addr_s[g]), .mem_dout(mem_dout_s[g]), .mem_w(mem_w_s[g]),
            .mem_din(mem_din_s[g]), .busy(busy_s[g]), .owner(owner_s[g])
        );
    end

    initial forever #5 clock = ~clock;

    // Memory macro per instance, driven only by the DUT's pins; read data lags the address by RD_LAT.
    logic [15:0] pmem [N][256];
    bit          pval [N][256];
    logic [15:0] ahist [N][8];

    always @(posedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (mem_w_s[k] === 1'b1) begin
                pmem[k][mem_addr_s[k][7:0]] <= mem_dout_s[k];
                pval[k][mem_addr_s[k][7:0]] <= 1'b1;
            end
            ahist[k][0] <= mem_addr_s[k];
            for (int j = 1; j < 8; j++) ahist[k][j] <= ahist[k][j-1];
        end
    end

    always_comb begin
        logic [7:0] ra;
        ra = 8'h00;
        for (int k = 0; k < N; k++) begin
            ra = ahist[k][rdl_of(k)-1][7:0];
            mem_din_s[k] = pval[k][ra] ? pmem[k][ra] : init_val(ra);
        end
    end

    task automatic chk1(input string name, input int k, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    task automatic chk16(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Model: each transaction is a timeline [start, start+len) of memory access then one ack cycle.
    int          cyc;
    bit          model_ok;
    bit          m_busy [N];
    bit          m_port [N];
    bit          m_wr [N];
    bit          m_owner [N];
    bit          m_last [N];
    int          m_start [N];
    int          m_len [N];
    logic [15:0] m_addr [N];
    logic [15:0] m_wdata [N];
    logic [15:0] m_rd0 [N];
    logic [15:0] m_rd1 [N];
    logic [15:0] mmem [N][256];
    bit          mval [N][256];

    function automatic logic [15:0] mread(input int k, input logic [15:0] a);
        return mval[k][a[7:0]] ? mmem[k][a[7:0]] : init_val(a[7:0]);
    endfunction

    task automatic model_step();
        int n;
        bit p;
        n = cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (m_busy[k] && m_wr[k] && (n - 1) == m_start[k]) begin
                mmem[k][m_addr[k][7:0]] = m_wdata[k];
                mval[k][m_addr[k][7:0]] = 1'b1;
            end
            if (reset) begin
                m_busy[k]  = 1'b0;
                m_owner[k] = 1'b0;
                m_last[k]  = 1'b1;
                m_rd0[k]   = 16'h0;
                m_rd1[k]   = 16'h0;
            end else if (!m_busy[k]) begin
                if (req0 || req1) begin
                    if (req0 && req1) p = (fpr_of(k) == 1) ? 1'b0 : !m_last[k];
                    else p = req1;
                    m_busy[k]  = 1'b1;
                    m_port[k]  = p;
                    m_owner[k] = p;
                    m_wr[k]    = p ? wr1 : wr0;
                    m_addr[k]  = p ? addr1 : addr0;
                    m_wdata[k] = p ? wdata1 : wdata0;
                    m_start[k] = n;
                    m_len[k]   = m_wr[k] ? 1 : rdl_of(k) + 1;
                end
            end else if (n == m_start[k] + m_len[k] + 1) begin
                m_busy[k] = 1'b0;
                m_last[k] = m_port[k];
            end else if (n == m_start[k] + m_len[k] && !m_wr[k]) begin
                if (m_port[k]) m_rd1[k] = mread(k, m_addr[k]);
                else m_rd0[k] = mread(k, m_addr[k]);
            end
        end
        cyc = n;
        if (reset) model_ok = 1'b1;
    endtask

    task automatic compare_all();
        bit in_acc, in_done;
        for (int k = 0; k < N; k++) begin
            in_acc  = m_busy[k] && (cyc < m_start[k] + m_len[k]);
            in_done = m_busy[k] && (cyc == m_start[k] + m_len[k]);
            chk1("busy", k, busy_s[k], m_busy[k]);
            chk1("mem_w", k, mem_w_s[k], in_acc && m_wr[k] && cyc == m_start[k]);
            chk16("mem_addr", k, mem_addr_s[k], in_acc ? m_addr[k] : 16'h0);
            if (in_acc && m_wr[k]) chk16("mem_dout", k, mem_dout_s[k], m_wdata[k]);
            chk1("ack0", k, ack0_s[k], in_done && !m_port[k]);
            chk1("ack1", k, ack1_s[k], in_done && m_port[k]);
            chk1("owner", k, owner_s[k], m_owner[k]);
            chk16("rdata0", k, rdata0_s[k], m_rd0[k]);
            chk16("rdata1", k, rdata1_s[k], m_rd1[k]);
        end
    endtask

    initial begin
        model_ok = 1'b0;
        cyc = 0;
        forever begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            if (model_ok) compare_all();
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_ack(input int k, input bit port, input int maxc, output int waited);
        waited = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            waited++;
            if (port ? ack1_s[k] === 1'b1 : ack0_s[k] === 1'b1) break;
        end
    endtask

    int ack_cyc [$];
    bit ack_prt [$];
    int k3_a0, k3_a1, waited;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; wr0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0;
        tick(3);
        reset = 1'b0;
        chk1("rst_busy", 0, busy_s[0], 1'b0);
        chk1("rst_owner", 0, owner_s[0], 1'b0);
        chk1("rst_mem_w", 0, mem_w_s[0], 1'b0);
        chk16("rst_mem_addr", 0, mem_addr_s[0], 16'h0);
        chk16("rst_rdata0", 0, rdata0_s[0], 16'h0);

        // single write, port 0
        req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
        tick(1);
        chk1("wr_mem_w", 0, mem_w_s[0], 1'b1);
        chk16("wr_mem_addr", 0, mem_addr_s[0], 16'h0010);
        chk16("wr_mem_dout", 0, mem_dout_s[0], 16'hBEEF);
        chk1("wr_busy", 0, busy_s[0], 1'b1);
        tick(1);
        chk1("wr_ack0", 0, ack0_s[0], 1'b1);
        chk1("wr_mem_w_off", 0, mem_w_s[0], 1'b0);
        req0 = 1'b0;
        tick(1);
        chk1("wr_idle", 0, busy_s[0], 1'b0);

        // single read, port 1, RD_LAT=2 variant
        req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0020;
        tick(1);
        chk16("rd_addr1", 1, mem_addr_s[1], 16'h0020);
        tick(1);
        chk16("rd_addr2", 1, mem_addr_s[1], 16'h0020);
        tick(1);
        chk16("rd_addr3", 1, mem_addr_s[1], 16'h0020);
        chk1("rd_noack", 1, ack1_s[1], 1'b0);
        chk16("rd_early", 1, rdata1_s[1], 16'h0);
        tick(1);
        chk1("rd_ack1", 1, ack1_s[1], 1'b1);
        chk16("rd_rdata1", 1, rdata1_s[1], 16'h1234);
        chk16("rd_rdata0", 1, rdata0_s[1], 16'h0);
        req1 = 1'b0;
        tick(3);

        // both ports writing continuously from reset release
        reset = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'hA0A0;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0031; wdata1 = 16'hB1B1;
        tick(1);
        reset = 1'b0;
        k3_a0 = 0; k3_a1 = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (ack0_s[0] === 1'b1) begin ack_cyc.push_back(i); ack_prt.push_back(1'b0); end
            if (ack1_s[0] === 1'b1) begin ack_cyc.push_back(i); ack_prt.push_back(1'b1); end
            if (ack0_s[3] === 1'b1) k3_a0++;
            if (ack1_s[3] === 1'b1) k3_a1++;
        end
        chk_int("rr_count", 0, ack_cyc.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < ack_cyc.size()) begin
                chk_int("rr_cycle", 0, ack_cyc[j], 2 + 3 * j);
                chk1("rr_port", 0, ack_prt[j], j[0]);
            end
        end
        chk_int("fp_ack0", 3, k3_a0, 4);
        chk_int("fp_ack1", 3, k3_a1, 0);
        req0 = 1'b0;
        wait_ack(3, 1'b1, 8, waited);
        chk_int("fp_port1_after_drop", 3, waited, 2);
        req1 = 1'b0;
        tick(2);

        // port 1 arrives while port 0 is in ACCESS
        req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0020;
        tick(1);
        req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0050; wdata1 = 16'hC0DE;
        wait_ack(0, 1'b0, 8, waited);
        chk_int("late_ack0_time", 0, waited, 2);
        chk16("late_rdata0", 0, rdata0_s[0], 16'h1234);
        req0 = 1'b0;
        tick(1);
        chk1("late_idle", 0, busy_s[0], 1'b0);
        tick(1);
        chk16("late_addr1", 0, mem_addr_s[0], 16'h0050);
        chk1("late_mem_w", 0, mem_w_s[0], 1'b1);
        chk1("late_owner", 0, owner_s[0], 1'b1);
        tick(1);
        chk1("late_ack1", 0, ack1_s[0], 1'b1);
        req1 = 1'b0;
        tick(12);

        // reset in the second ACCESS cycle of a RD_LAT=3 read
        req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0040;
        tick(2);
        chk16("mid_addr", 2, mem_addr_s[2], 16'h0040);
        chk16("mid_rdata0_before", 2, rdata0_s[2], 16'h1234);
        reset = 1'b1;
        req0 = 1'b0;
        tick(1);
        chk1("mid_busy", 2, busy_s[2], 1'b0);
        chk16("mid_mem_addr", 2, mem_addr_s[2], 16'h0);
        chk1("mid_mem_w", 2, mem_w_s[2], 1'b0);
        chk1("mid_ack0", 2, ack0_s[2], 1'b0);
        chk16("mid_rdata0", 2, rdata0_s[2], 16'h0);
        chk1("mid_owner", 2, owner_s[2], 1'b0);
        reset = 1'b0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0060; wdata0 = 16'h1111;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0061; wdata1 = 16'h2222;
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            waited++;
            if (ack0_s[2] === 1'b1 || ack1_s[2] === 1'b1) break;
        end
        chk_int("tie_after_rst_time", 2, waited, 2);
        chk1("tie_after_rst_ack0", 2, ack0_s[2], 1'b1);
        chk1("tie_after_rst_ack1", 2, ack1_s[2], 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
